// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, parks a response that lands during a stall, and flushes on redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  // Handshake: a request transfers on a cycle with imem_req && imem_gnt; its single
  // response arrives later as an imem_rvalid pulse, accepted only while in S_WAIT.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] buf_instr;
  logic        discard;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      discard   <= 1'b0;
      buf_instr <= NOP_INSTR;
      o_pc      <= 32'h0;
      o_instr   <= NOP_INSTR;
      o_valid   <= 1'b0;
    end else if (i_redirect) begin
      fetch_pc <= i_redirect_pc & ~32'd3;
      o_valid  <= 1'b0;
      o_instr  <= NOP_INSTR;
      case (state)
        S_REQ: begin
          // A request granted this cycle is already in flight; its data must be dropped.
          if (imem_gnt) begin
            discard <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            state   <= S_REQ;
          end else begin
            discard <= 1'b1;
          end
        end
        S_HOLD:  state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      if (!i_stall) begin
        o_valid <= 1'b0;
        o_instr <= NOP_INSTR;
      end
      case (state)
        S_REQ: begin
          if (imem_gnt) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else if (!i_stall) begin
              o_pc     <= fetch_pc;
              o_instr  <= imem_rdata;
              o_valid  <= 1'b1;
              fetch_pc <= fetch_pc + 32'd4;
              state    <= S_REQ;
            end else begin
              // fetch_pc stays put in HOLD, so it doubles as the buffered PC.
              buf_instr <= imem_rdata;
              state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            o_pc     <= fetch_pc;
            o_instr  <= buf_instr;
            o_valid  <= 1'b1;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
